// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: filters the PS/2 clock, deframes 11-bit frames, folds
// E0/F0 prefixes into key events and queues them in a fall-through FIFO.
module ps2_key_event_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int EMIT_MAKE   = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ps2c,
  input  logic                          i_ps2d,
  input  logic                          i_rx_en,
  output logic                          o_key_valid,
  input  logic                          i_key_ready,
  output logic [7:0]                    o_key_code,
  output logic                          o_key_ext,
  output logic                          o_key_brk,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [FILTER_LEN-1:0] r_samp;
  logic                  r_fclk;
  logic                  r_fall;
  logic                  w_all0;
  logic                  w_all1;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [10:0]           r_shift;
  logic [TW-1:0]         r_idle;
  logic                  w_timeout;
  logic                  r_ext_pend;
  logic                  r_brk_pend;

  logic                  w_in_check;
  logic                  w_bad_frame;
  logic                  w_bad_par;
  logic                  w_byte_ok;
  logic [7:0]            w_byte;
  logic                  w_push;

  logic [9:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [LW-1:0]         r_level;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;

  assign w_all0 = ~|r_samp;
  assign w_all1 = &r_samp;

  // Filtered clock starts low so a high idle line after reset never yields a fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_samp <= '0;
      r_fclk <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_samp <= {r_samp[FILTER_LEN-2:0], i_ps2c};
      r_fall <= r_fclk & w_all0;
      if (w_all1)
        r_fclk <= 1'b1;
      else if (w_all0)
        r_fclk <= 1'b0;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:  if (r_fall && i_rx_en) w_next = S_SHIFT;
      S_SHIFT: begin
        if (r_fall && r_cnt == 4'd0) begin
          w_next = S_CHECK;
        end else if (!r_fall && r_idle == TW'(TIMEOUT_CYC - 1)) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_CHECK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame register: start bit lands in [0], data [8:1], parity [9], stop [10].
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_shift <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (r_fall && i_rx_en) begin
            r_shift <= {i_ps2d, r_shift[10:1]};
            r_cnt   <= 4'd9;
            r_idle  <= '0;
          end
        end
        S_SHIFT: begin
          if (r_fall) begin
            r_shift <= {i_ps2d, r_shift[10:1]};
            r_idle  <= '0;
            if (r_cnt != 4'd0)
              r_cnt <= r_cnt - 4'd1;
          end else begin
            r_idle <= r_idle + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_in_check   = (r_state == S_CHECK);
  assign w_bad_frame  = w_in_check & (r_shift[0] | ~r_shift[10]);
  assign w_bad_par    = w_in_check & ~w_bad_frame & ~(^r_shift[9:1]);
  assign w_byte_ok    = w_in_check & ~w_bad_frame & ~w_bad_par;
  assign w_byte       = r_shift[8:1];
  assign w_push       = w_byte_ok && w_byte != 8'hE0 && w_byte != 8'hF0 &&
                        (r_brk_pend || EMIT_MAKE != 0);
  assign o_frame_err  = w_bad_frame | w_timeout;
  assign o_parity_err = w_bad_par;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (o_frame_err || o_parity_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_byte_ok) begin
      if (w_byte == 8'hE0) begin
        r_ext_pend <= 1'b1;
      end else if (w_byte == 8'hF0) begin
        r_brk_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  assign o_key_valid  = (r_level != '0);
  assign w_pop        = o_key_valid & i_key_ready;
  assign w_full       = (r_level == LW'(FIFO_DEPTH));
  assign w_wr         = w_push & (~w_full | w_pop);
  assign o_overflow   = w_push & w_full & ~w_pop;
  assign o_fifo_level = r_level;
  assign o_key_code   = o_key_valid ? r_mem[r_rp][7:0] : 8'h00;
  assign o_key_brk    = o_key_valid & r_mem[r_rp][8];
  assign o_key_ext    = o_key_valid & r_mem[r_rp][9];

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {r_ext_pend, r_brk_pend, w_byte};
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule
